// File: rtl/hls_cfg_pkg.sv
// rtl/hls_cfg_pkg.sv - shared types and constants for the HLS control-register master
package hls_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        FINISH
    } state_e;

    localparam logic [31:0] CTRL_ADDR    = 32'h0000_0000;
    localparam logic [31:0] AP_START_VAL = 32'h0000_0001;
    localparam int          AP_DONE_BIT  = 1;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;

endpackage

// File: rtl/hls_cfg_poll_timer.sv
// rtl/hls_cfg_poll_timer.sv - saturating count of completed status reads with limit detection
module hls_cfg_poll_timer #(
    parameter int unsigned POLL_LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic incr,
    output logic limit_hit
);

    // A zero limit would make the counter zero-width; treat it as a single read.
    localparam int unsigned LIM = (POLL_LIMIT == 0) ? 1 : POLL_LIMIT;
    localparam int unsigned CW  = $clog2(LIM + 1);
    localparam logic [CW-1:0] LIM_C = CW'(LIM);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (incr && (count_q != LIM_C)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Asserted on the increment that brings the count up to the limit.
    assign limit_hit = incr && (count_q >= (LIM_C - 1'b1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/hls_config_master.sv
// rtl/hls_config_master.sv - AXI4-Lite master that starts an HLS core and polls ap_done
// Optional poll timeout enabled by defining HLS_CFG_POLL_TIMEOUT_EN.
module hls_config_master
    import hls_cfg_pkg::*;
#(
    parameter int C_S_AXI_CONFIG_ADDR_WIDTH = 5,
    parameter int C_S_AXI_CONFIG_DATA_WIDTH = 32,
    parameter int POLL_LIMIT                = 255
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cmd_start,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   error,
    output logic                                   timeout,
    output logic                                   m_axi_config_AWVALID,
    input  logic                                   m_axi_config_AWREADY,
    output logic [C_S_AXI_CONFIG_ADDR_WIDTH-1:0]   m_axi_config_AWADDR,
    output logic                                   m_axi_config_WVALID,
    input  logic                                   m_axi_config_WREADY,
    output logic [C_S_AXI_CONFIG_DATA_WIDTH-1:0]   m_axi_config_WDATA,
    output logic [C_S_AXI_CONFIG_DATA_WIDTH/8-1:0] m_axi_config_WSTRB,
    input  logic                                   m_axi_config_BVALID,
    output logic                                   m_axi_config_BREADY,
    input  logic [1:0]                             m_axi_config_BRESP,
    output logic                                   m_axi_config_ARVALID,
    input  logic                                   m_axi_config_ARREADY,
    output logic [C_S_AXI_CONFIG_ADDR_WIDTH-1:0]   m_axi_config_ARADDR,
    input  logic                                   m_axi_config_RVALID,
    output logic                                   m_axi_config_RREADY,
    input  logic [C_S_AXI_CONFIG_DATA_WIDTH-1:0]   m_axi_config_RDATA,
    input  logic [1:0]                             m_axi_config_RRESP
);

    localparam int AW = C_S_AXI_CONFIG_ADDR_WIDTH;
    localparam int DW = C_S_AXI_CONFIG_DATA_WIDTH;
    localparam int SW = C_S_AXI_CONFIG_DATA_WIDTH / 8;

    state_e          state_q, state_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            bready_q, bready_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic [AW-1:0]   awaddr_q, awaddr_d;
    logic [AW-1:0]   araddr_q, araddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic            timeout_q, timeout_d;

    logic            aw_fire;
    logic            w_fire;
    logic            poll_clear;
    logic            poll_incr;
    logic            poll_expired;

    assign aw_fire = awvalid_q && m_axi_config_AWREADY;
    assign w_fire  = wvalid_q && m_axi_config_WREADY;

`ifdef HLS_CFG_POLL_TIMEOUT_EN
    hls_cfg_poll_timer #(
        .POLL_LIMIT (POLL_LIMIT)
    ) u_poll_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (poll_clear),
        .incr      (poll_incr),
        .limit_hit (poll_expired)
    );
`else
    logic unused_poll;
    assign poll_expired = 1'b0;
    assign unused_poll  = poll_clear ^ poll_incr ^ (POLL_LIMIT == 0);
`endif

    // Only ap_done is inspected in the status word.
    logic unused_rdata;
    assign unused_rdata = ^m_axi_config_RDATA;

    always_comb begin
        state_d    = state_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        awaddr_d   = awaddr_q;
        araddr_d   = araddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        error_d    = error_q;
        timeout_d  = timeout_q;
        done_d     = 1'b0;
        poll_clear = 1'b0;
        poll_incr  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    state_d    = WR_ADDR_DATA;
                    awvalid_d  = 1'b1;
                    wvalid_d   = 1'b1;
                    awaddr_d   = AW'(CTRL_ADDR);
                    wdata_d    = DW'(AP_START_VAL);
                    wstrb_d    = '1;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    error_d    = 1'b0;
                    timeout_d  = 1'b0;
                    poll_clear = 1'b1;
                end
            end

            WR_ADDR_DATA: begin
                if (aw_fire) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_fire) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end

            WR_RESP: begin
                if (m_axi_config_BVALID) begin
                    bready_d = 1'b0;
                    if (m_axi_config_BRESP != RESP_OKAY) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        arvalid_d = 1'b1;
                        araddr_d  = AW'(CTRL_ADDR);
                        state_d   = RD_ADDR;
                    end
                end
            end

            RD_ADDR: begin
                if (m_axi_config_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end

            RD_DATA: begin
                if (m_axi_config_RVALID) begin
                    rready_d = 1'b0;
                    if (m_axi_config_RRESP != RESP_OKAY) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        poll_incr = 1'b1;
                        if (m_axi_config_RDATA[AP_DONE_BIT]) begin
                            done_d  = 1'b1;
                            state_d = FINISH;
                        end else if (poll_expired) begin
                            timeout_d = 1'b1;
                            error_d   = 1'b1;
                            done_d    = 1'b1;
                            state_d   = FINISH;
                        end else begin
                            arvalid_d = 1'b1;
                            araddr_d  = AW'(CTRL_ADDR);
                            state_d   = RD_ADDR;
                        end
                    end
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // busy is registered alongside the state so it mirrors "not IDLE" exactly.
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy                 = busy_q;
    assign done                 = done_q;
    assign error                = error_q;
    assign timeout              = timeout_q;
    assign m_axi_config_AWVALID = awvalid_q;
    assign m_axi_config_AWADDR  = awaddr_q;
    assign m_axi_config_WVALID  = wvalid_q;
    assign m_axi_config_WDATA   = wdata_q;
    assign m_axi_config_WSTRB   = wstrb_q;
    assign m_axi_config_BREADY  = bready_q;
    assign m_axi_config_ARVALID = arvalid_q;
    assign m_axi_config_ARADDR  = araddr_q;
    assign m_axi_config_RREADY  = rready_q;

endmodule

// File: tb/tb_hls_config_master.sv
// tb/tb_hls_config_master.sv - self-checking bench for hls_config_master with a behavioural AXI4-Lite slave
module tb_hls_config_master;

`ifdef HLS_CFG_POLL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int LIMIT = TO_EN ? 4 : 255;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk;
    logic          rst;
    logic          cmd_start;
    logic          busy, done, error, timeout;
    logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic          ARVALID, ARREADY, RVALID, RREADY;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [DW-1:0] WDATA, RDATA;
    logic [3:0]    WSTRB;
    logic [1:0]    BRESP, RRESP;

    hls_config_master #(
        .C_S_AXI_CONFIG_ADDR_WIDTH (AW),
        .C_S_AXI_CONFIG_DATA_WIDTH (DW),
        .POLL_LIMIT                (LIMIT)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .cmd_start            (cmd_start),
        .busy                 (busy),
        .done                 (done),
        .error                (error),
        .timeout              (timeout),
        .m_axi_config_AWVALID (AWVALID),
        .m_axi_config_AWREADY (AWREADY),
        .m_axi_config_AWADDR  (AWADDR),
        .m_axi_config_WVALID  (WVALID),
        .m_axi_config_WREADY  (WREADY),
        .m_axi_config_WDATA   (WDATA),
        .m_axi_config_WSTRB   (WSTRB),
        .m_axi_config_BVALID  (BVALID),
        .m_axi_config_BREADY  (BREADY),
        .m_axi_config_BRESP   (BRESP),
        .m_axi_config_ARVALID (ARVALID),
        .m_axi_config_ARREADY (ARREADY),
        .m_axi_config_ARADDR  (ARADDR),
        .m_axi_config_RVALID  (RVALID),
        .m_axi_config_RREADY  (RREADY),
        .m_axi_config_RDATA   (RDATA),
        .m_axi_config_RRESP   (RRESP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // slave configuration
    int         aw_delay, w_delay, b_delay, ar_delay, r_delay, done_at;
    logic [1:0] bresp_cfg, rresp_cfg;

    // observation counters
    int aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_cyc, viol, payload_bad, done_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural slave and protocol monitor; decisions at negedge take effect at the next posedge.
    initial begin : slave
        int  aw_wait, w_wait, ar_wait, b_wait, r_wait;
        bit  b_fire, r_fire, done_prev;
        bit  p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
        logic [AW-1:0] p_awaddr, p_araddr;
        logic [DW-1:0] p_wdata;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        b_fire = 0; r_fire = 0; done_prev = 0;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
        p_awaddr = 0; p_araddr = 0; p_wdata = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
                b_fire = 0; r_fire = 0; done_prev = 0;
                p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
                continue;
            end
            if (BREADY && !(aw_hs == w_hs && aw_hs == b_hs + 1)) viol++;
            if (RREADY && ar_hs != r_hs + 1) viol++;
            if (p_awv && !p_awr && (!AWVALID || AWADDR !== p_awaddr)) viol++;
            if (p_wv && !p_wr && (!WVALID || WDATA !== p_wdata)) viol++;
            if (p_arv && !p_arr && (!ARVALID || ARADDR !== p_araddr)) viol++;
            if ((AWVALID || WVALID || BREADY || ARVALID || RREADY) && !busy) viol++;
            if (done) begin
                done_cnt++;
                if (done_prev || !busy) viol++;
            end
            done_prev = done;
            if (AWVALID) aw_cyc++;

            if (b_fire) begin
                BVALID = 0; b_fire = 0; b_wait = 0;
            end else if (!BVALID && aw_hs > b_hs && w_hs > b_hs) begin
                if (b_wait >= b_delay) begin BVALID = 1; BRESP = bresp_cfg; end
                else b_wait++;
            end
            if (BVALID && BREADY) begin b_fire = 1; b_hs++; end

            if (r_fire) begin
                RVALID = 0; r_fire = 0; r_wait = 0;
            end else if (!RVALID && ar_hs > r_hs) begin
                if (r_wait >= r_delay) begin
                    RVALID = 1;
                    RRESP  = rresp_cfg;
                    RDATA  = (r_hs == done_at) ? ($urandom | 32'h2) : ($urandom & ~32'h2);
                end else r_wait++;
            end
            if (RVALID && RREADY) begin r_fire = 1; r_hs++; end

            if (AWVALID) begin
                if (aw_wait >= aw_delay) begin
                    AWREADY = 1; aw_hs++; aw_wait = 0;
                    if (AWADDR !== 0) payload_bad++;
                end else begin AWREADY = 0; aw_wait++; end
            end else begin AWREADY = 0; aw_wait = 0; end
            if (WVALID) begin
                if (w_wait >= w_delay) begin
                    WREADY = 1; w_hs++; w_wait = 0;
                    if (WDATA !== 32'h1 || WSTRB !== 4'hF) payload_bad++;
                end else begin WREADY = 0; w_wait++; end
            end else begin WREADY = 0; w_wait = 0; end
            if (ARVALID) begin
                if (ar_wait >= ar_delay) begin
                    ARREADY = 1; ar_hs++; ar_wait = 0;
                    if (ARADDR !== 0) payload_bad++;
                end else begin ARREADY = 0; ar_wait++; end
            end else begin ARREADY = 0; ar_wait = 0; end

            p_awv = AWVALID; p_awr = AWREADY; p_awaddr = AWADDR;
            p_wv  = WVALID;  p_wr  = WREADY;  p_wdata  = WDATA;
            p_arv = ARVALID; p_arr = ARREADY; p_araddr = ARADDR;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, ".valids"}, {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 5'b0);
        check({tag, ".flags"}, {busy, done, error, timeout}, 4'b0);
        check({tag, ".awaddr"}, AWADDR, 0);
        check({tag, ".araddr"}, ARADDR, 0);
        check({tag, ".wdata"}, WDATA, 0);
        check({tag, ".wstrb"}, WSTRB, 0);
    endtask

    task automatic start_cmd(input int ad, input int wd, input int bd, input int ard, input int rd,
                             input logic [1:0] br, input logic [1:0] rr, input int dat);
        @(posedge clk); #1;
        aw_delay = ad; w_delay = wd; b_delay = bd; ar_delay = ard; r_delay = rd;
        bresp_cfg = br; rresp_cfg = rr; done_at = dat;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        aw_cyc = 0; viol = 0; payload_bad = 0; done_cnt = 0;
        cmd_start = 1;
        @(posedge clk); #1;
        cmd_start = 0;
    endtask

    task automatic run_cmd(input string name, input int ad, input int wd, input int bd, input int ard,
                           input int rd, input logic [1:0] br, input logic [1:0] rr, input int dat,
                           input bit poke);
        bit got;
        int exp_reads;
        bit exp_err, exp_to;
        start_cmd(ad, wd, bd, ard, rd, br, rr, dat);
        check({name, ".first_valids"}, {AWVALID, WVALID, busy}, 3'b111);
        check({name, ".flags_cleared"}, {error, timeout}, 2'b00);
        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(posedge clk); #1;
            cmd_start = poke && (i == 3) && busy && !done;
            if (done) got = 1;
        end
        cmd_start = 0;
        check({name, ".done_seen"}, got, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // reference outcome from the command rules
        if (br != 2'b00) begin
            exp_reads = 0; exp_err = 1; exp_to = 0;
        end else if (rr != 2'b00) begin
            exp_reads = 1; exp_err = 1; exp_to = 0;
        end else if (TO_EN && (dat + 1 > LIMIT)) begin
            exp_reads = LIMIT; exp_err = 1; exp_to = 1;
        end else begin
            exp_reads = dat + 1; exp_err = 0; exp_to = 0;
        end

        check({name, ".aw_hs"}, aw_hs, 1);
        check({name, ".w_hs"}, w_hs, 1);
        check({name, ".b_hs"}, b_hs, 1);
        check({name, ".ar_hs"}, ar_hs, exp_reads);
        check({name, ".r_hs"}, r_hs, exp_reads);
        check({name, ".done_cnt"}, done_cnt, 1);
        check({name, ".error"}, error, exp_err);
        check({name, ".timeout"}, timeout, exp_to);
        check({name, ".busy_idle"}, busy, 1'b0);
        check({name, ".aw_cycles"}, aw_cyc, ad + 1);
        check({name, ".protocol"}, viol, 0);
        check({name, ".payload"}, payload_bad, 0);
        check({name, ".idle_valids"}, {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 5'b0);
    endtask

    initial begin : stim
        bit reached;
        rst = 1; cmd_start = 0;
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
        bresp_cfg = 0; rresp_cfg = 0; done_at = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        aw_cyc = 0; viol = 0; payload_bad = 0; done_cnt = 0;
        #1;
        check_all_zero("reset_async");
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;
        check_all_zero("reset_release");

        run_cmd("basic", 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        run_cmd("aw_late", 3, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        run_cmd("w_late", 0, 2, 0, 1, 1, 2'b00, 2'b00, 1, 0);
        run_cmd("poll5", 0, 0, 0, 1, 2, 2'b00, 2'b00, 4, 1);
        run_cmd("bresp_err", 1, 1, 0, 0, 0, 2'b10, 2'b00, 0, 0);
        run_cmd("recover", 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        run_cmd("rresp_err", 0, 0, 0, 0, 0, 2'b00, 2'b11, 3, 0);
        run_cmd("long_poll", 0, 0, 0, 0, 0, 2'b00, 2'b00, 20, 1);

        for (int k = 0; k < 6; k++) begin
            run_cmd($sformatf("rand%0d", k),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00,
                    ($urandom_range(0, 5) == 0) ? 2'b11 : 2'b00,
                    $urandom_range(0, 6), 1'b1);
        end

        // reset while waiting in the read-data phase; slave never answers the read
        start_cmd(0, 0, 0, 0, 100000, 2'b00, 2'b00, 100000);
        reached = 0;
        for (int i = 0; i < 100 && !reached; i++) begin
            @(posedge clk); #1;
            if (RREADY) reached = 1;
        end
        check("rst.reach_rd_data", reached, 1'b1);
        cmd_start = 1;
        @(posedge clk); #1;
        cmd_start = 0;
        check("rst.busy_cmd_ignored", {AWVALID, RREADY, busy}, 3'b011);
        check("rst.single_write", aw_hs, 1);
        @(posedge clk); #1;
        #2 rst = 1;
        #1;
        check_all_zero("rst_mid");
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;
        check_all_zero("rst_mid_release");

        run_cmd("after_rst", 0, 1, 0, 0, 0, 2'b00, 2'b00, 2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hls_config_master.md
HLS_CONFIG_MASTER -- requirements
Module: hls_config_master

Interface
REQ-001 SHALL have parameter C_S_AXI_CONFIG_ADDR_WIDTH, default 5, AXI4-Lite address width.
REQ-002 SHALL have parameter C_S_AXI_CONFIG_DATA_WIDTH, default 32, AXI4-Lite data width.
REQ-003 SHALL have parameter POLL_LIMIT, default 255, maximum status reads per command (used only with the timeout macro).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port cmd_start, input, 1, one-cycle start request.
REQ-007 SHALL have ports busy/done/error/timeout, output, 1 each: in progress; 1-cycle completion pulse; sticky failure flag; sticky timeout flag.
REQ-008 SHALL have ports m_axi_config_AWVALID out 1, AWREADY in 1, AWADDR out ADDR_WIDTH.
REQ-009 SHALL have ports m_axi_config_WVALID out 1, WREADY in 1, WDATA out DATA_WIDTH, WSTRB out DATA_WIDTH/8.
REQ-010 SHALL have ports m_axi_config_BVALID in 1, BREADY out 1, BRESP in 2.
REQ-011 SHALL have ports m_axi_config_ARVALID out 1, ARREADY in 1, ARADDR out ADDR_WIDTH.
REQ-012 SHALL have ports m_axi_config_RVALID in 1, RREADY out 1, RDATA in DATA_WIDTH, RRESP in 2.

Function
REQ-013 SHALL implement states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, FINISH.
REQ-014 SHALL, on cmd_start in IDLE, enter WR_ADDR_DATA and assert AWVALID and WVALID together next cycle: AWADDR=CTRL_ADDR (0x00), WDATA=0x1 (ap_start), WSTRB=all ones.
REQ-015 SHALL hold each VALID and its payload stable until its READY is sampled high, then drop that VALID independently; AW and W may complete in the same or different cycles.
REQ-016 SHALL enter WR_RESP only after both AW and W handshakes, assert BREADY there only, and on BVALID leave it.
REQ-017 SHALL, if BRESP != OKAY, set error and go to FINISH; else go to RD_ADDR.
REQ-018 SHALL in RD_ADDR drive ARVALID, ARADDR=CTRL_ADDR, until ARREADY; then RD_DATA with RREADY high.
REQ-019 SHALL, on RVALID: RRESP != OKAY sets error and goes FINISH; RDATA[1] (ap_done)=1 goes FINISH; otherwise reissue RD_ADDR the next cycle.
REQ-020 SHALL in FINISH pulse done for exactly one cycle, then return to IDLE.
REQ-021 SHALL hold busy=1 in every state except IDLE.
REQ-022 SHALL ignore cmd_start when not in IDLE; error and timeout clear on the next accepted cmd_start.
REQ-023 SHALL register every output; no combinational path from any input to any output.

Reset
REQ-024 SHALL, on rst, force state IDLE and all VALID/READY, busy, done, error, timeout, and poll count to 0, AWADDR/ARADDR/WDATA/WSTRB to 0, immediately and irrespective of clk.
REQ-025 SHALL, on reset mid-transaction, abandon it without completing any handshake; the slave shares the reset.

Configuration
REQ-026 SHALL, with HLS_CFG_POLL_TIMEOUT_EN defined, count completed status reads and, when the count reaches POLL_LIMIT without ap_done, set timeout and error and go to FINISH.
REQ-027 SHALL, without HLS_CFG_POLL_TIMEOUT_EN, poll indefinitely; timeout stays 0; the counter is not built.

Structure
REQ-028 SHALL place in package hls_cfg_pkg: state enum, CTRL_ADDR, AP_START_VAL (0x1), AP_DONE_BIT (1), RESP_OKAY (2'b00).
REQ-029 SHALL put the poll counter in sub-module hls_cfg_poll_timer (clear, increment, limit-reached), instantiated only under the macro.

Verification
REQ-030 SHALL cover: cmd_start, AWREADY/WREADY=1, BRESP=0, RDATA=0x2 on first read -> one write of 0x1 to 0x00, one read, done pulse, error=0.
REQ-031 SHALL cover: AWREADY 3 cycles after WREADY -> WVALID drops after its handshake, AWVALID held stable with AWADDR 0x00 for 3 cycles, BREADY only after both.
REQ-032 SHALL cover: RDATA=0x0 four times then 0x2 -> exactly five AR handshakes, done once.
REQ-033 SHALL cover: BRESP=2'b10 -> error=1, done pulse, no AR issued.
REQ-034 SHALL cover (macro on, POLL_LIMIT=4): RDATA always 0 -> four reads, timeout=1, error=1, done pulse.
REQ-035 SHALL cover: rst asserted in RD_DATA -> all outputs 0 same cycle; cmd_start in busy ignored.
